display_mux_sequencer: RTL and testbench

- Registered N-channel, W-bit display source selector for the clock's display path; successor to the fixed 4:1 40-bit combinational selector.
- Adds manual, auto-rotate and freeze modes, a per-channel enable mask, and a dwell timer driven by the 1 Hz tick. In auto mode the display cycles through, for example, time, date, alarm and timer views.
- Sits between the view-formatting blocks and the segment-encoding stage.

---
 rtl/display_mux_sequencer_pkg.sv | 7 +
 rtl/display_mux_sequencer_next_enabled_finder.sv | 28 ++
 rtl/display_mux_sequencer.sv | 65 ++++++
 tb/tb_display_mux_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/display_mux_sequencer_pkg.sv
// display_mux_sequencer_pkg: mode encodings and blank pattern for the display source selector
package display_mux_sequencer_pkg;
  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_AUTO = 2'b01;
  localparam logic [1:0] MODE_FREEZE = 2'b10;
  localparam logic BLANK_BIT = 1'b0;
endpackage

// File: rtl/display_mux_sequencer_next_enabled_finder.sv
// next_enabled_finder: first enabled channel above cur_sel with wrap, excluding cur_sel itself
module next_enabled_finder #(
  parameter int CHANNELS = 4,
  parameter int SEL_W = 2
) (
  input  logic [CHANNELS-1:0] ch_en,
  input  logic [SEL_W-1:0]    cur_sel,
  output logic [SEL_W-1:0]    next_sel,
  output logic                found
);
  logic [2*CHANNELS-1:0] dbl;
  logic [CHANNELS-2:0] rot;
  logic [SEL_W-1:0] off;
  logic [SEL_W:0] sum;
  assign dbl = {ch_en, ch_en};
  assign rot = (CHANNELS-1)'(dbl >> (cur_sel + SEL_W'(1)));
  always_comb begin
    off = '0;
    found = 1'b0;
    for (int i = CHANNELS-2; i >= 0; i--)
      if (rot[i]) begin
        off = SEL_W'(i);
        found = 1'b1;
      end
  end
  assign sum = {1'b0, cur_sel} + {1'b0, off} + (SEL_W+1)'(1);
  assign next_sel = sum >= (SEL_W+1)'(CHANNELS) ? SEL_W'(sum - (SEL_W+1)'(CHANNELS)) : sum[SEL_W-1:0];
endmodule

// File: rtl/display_mux_sequencer.sv
// display_mux_sequencer: registered N-channel display source selector with manual, auto-rotate and freeze modes
module display_mux_sequencer
  import display_mux_sequencer_pkg::*;
#(
  parameter int WIDTH = 40,
  parameter int CHANNELS = 4,
  parameter int SEL_W = 2,
  parameter int DWELL_TICKS = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic [CHANNELS*WIDTH-1:0] src,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      load,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      switched
);
  logic [WIDTH-1:0] ch [CHANNELS];
  logic [7:0] dwell, dwell_base, dwell_nxt;
  logic [1:0] prev_mode;
  logic [SEL_W-1:0] next_sel, sel_nxt;
  logic found, load_ok, cur_en, expire;
  for (genvar i = 0; i < CHANNELS; i++) assign ch[i] = src[i*WIDTH +: WIDTH];
  next_enabled_finder #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_finder (
    .ch_en(ch_en),
    .cur_sel(cur_sel),
    .next_sel(next_sel),
    .found(found)
  );
  assign cur_en = ch_en[cur_sel];
  assign load_ok = load && ({1'b0, sel_in} < (SEL_W+1)'(CHANNELS)) && ch_en[sel_in];
  assign dwell_base = mode != prev_mode ? 8'd0 : dwell;
  assign expire = !cur_en || ({1'b0, dwell_base} + 9'd1 >= 9'(DWELL_TICKS));
  always_comb begin
    sel_nxt = cur_sel;
    dwell_nxt = dwell_base;
    if (mode == MODE_MANUAL && load_ok)
      sel_nxt = sel_in;
    else if (mode == MODE_AUTO && load_ok) begin
      sel_nxt = sel_in;
      dwell_nxt = 8'd0;
    end else if (mode == MODE_AUTO && tick) begin
      sel_nxt = expire && found ? next_sel : cur_sel;
      dwell_nxt = expire ? 8'd0 : dwell_base + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out <= '0;
      cur_sel <= '0;
      dwell <= '0;
      switched <= 1'b0;
      prev_mode <= MODE_MANUAL;
    end else begin
      cur_sel <= sel_nxt;
      dwell <= dwell_nxt;
      switched <= sel_nxt != cur_sel;
      prev_mode <= mode;
      if (!mode[1]) out <= cur_en ? ch[cur_sel] : {WIDTH{BLANK_BIT}};
    end
endmodule

// File: tb/tb_display_mux_sequencer.sv
// tb_display_mux_sequencer: directed plus randomized checks against a behavioural model
module tb_display_mux_sequencer;
  localparam int W = 40;
  localparam int C = 4;
  localparam int SW = 2;
  localparam int DT = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic load = 1'b0;
  logic [C*W-1:0] src;
  logic [C-1:0] ch_en;
  logic [1:0] mode;
  logic [SW-1:0] sel_in;
  logic [W-1:0] out;
  logic [SW-1:0] cur_sel;
  logic switched;
  logic [W-1:0] srcw [C];
  int checks = 0;
  int failures = 0;
  int m_sel, m_dw, m_pm;
  logic [W-1:0] m_out;
  logic m_sw;
  display_mux_sequencer #(.WIDTH(W), .CHANNELS(C), .SEL_W(SW), .DWELL_TICKS(DT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick),
    .src(src),
    .ch_en(ch_en),
    .mode(mode),
    .sel_in(sel_in),
    .load(load),
    .out(out),
    .cur_sel(cur_sel),
    .switched(switched)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int nxt(input int s);
    for (int k = 1; k < C; k++) if (ch_en[(s+k)%C]) return (s+k)%C;
    return s;
  endfunction
  task automatic pack();
    for (int k = 0; k < C; k++) src[k*W +: W] = srcw[k];
  endtask
  task automatic mreset();
    m_sel = 0;
    m_dw = 0;
    m_pm = 0;
    m_out = '0;
    m_sw = 1'b0;
  endtask
  task automatic step();
    int ns = m_sel;
    int nd = (int'(mode) != m_pm) ? 0 : m_dw;
    logic [W-1:0] no = m_out;
    bit vl = load && ch_en[sel_in];
    if (mode == 2'd0 && vl) ns = int'(sel_in);
    else if (mode == 2'd1 && vl) begin
      ns = int'(sel_in);
      nd = 0;
    end else if (mode == 2'd1 && tick) begin
      if (!ch_en[m_sel] || nd + 1 >= DT) begin
        nd = 0;
        ns = nxt(m_sel);
      end else nd++;
    end
    if (mode < 2'd2) no = ch_en[m_sel] ? srcw[m_sel] : '0;
    @(posedge clk);
    m_sw = ns != m_sel;
    m_sel = ns;
    m_dw = nd;
    m_out = no;
    m_pm = int'(mode);
    #1;
    chk("out", 64'(out), 64'(m_out));
    chk("cur_sel", 64'(cur_sel), 64'(m_sel));
    chk("switched", 64'(switched), 64'(m_sw));
  endtask
  initial begin
    int n;
    mode = 2'd0;
    ch_en = 4'b1111;
    sel_in = '0;
    for (int k = 0; k < C; k++) srcw[k] = W'(k + 1);
    pack();
    mreset();
    #12;
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_sel", 64'(cur_sel), 64'd0);
    chk("rst_sw", 64'(switched), 64'd0);
    rst_n = 1'b1;
    step();
    step();
    load = 1'b1; sel_in = 2'd2; step(); load = 1'b0;
    chk("t1_sel", 64'(cur_sel), 64'd2);
    chk("t1_sw", 64'(switched), 64'd1);
    step();
    chk("t1_out", 64'(out), 64'h3);
    chk("t1_sw_once", 64'(switched), 64'd0);
    ch_en = 4'b1011;
    load = 1'b1; sel_in = 2'd1; step();
    sel_in = 2'd2; step(); load = 1'b0;
    chk("t2_sel", 64'(cur_sel), 64'd1);
    chk("t2_sw", 64'(switched), 64'd0);
    ch_en = 4'b1101;
    load = 1'b1; sel_in = 2'd0; step(); load = 1'b0;
    step();
    mode = 2'd1;
    step();
    n = 0;
    for (int t = 1; t <= 20; t++) begin
      tick = 1'b1; step(); tick = 1'b0;
      n += int'(switched);
      if (t == 5) chk("t3_sel5", 64'(cur_sel), 64'd2);
      if (t == 10) chk("t3_sel10", 64'(cur_sel), 64'd3);
      if (t == 15) chk("t3_sel15", 64'(cur_sel), 64'd0);
      step();
    end
    chk("t3_switches", 64'(n), 64'd4);
    for (int t = 0; t < 2; t++) begin
      tick = 1'b1; step(); tick = 1'b0; step();
    end
    ch_en = 4'b1001;
    step();
    chk("t4_blank", 64'(out), 64'd0);
    chk("t4_hold", 64'(cur_sel), 64'd2);
    tick = 1'b1; step(); tick = 1'b0;
    chk("t4_adv", 64'(cur_sel), 64'd3);
    for (int t = 0; t < 4; t++) begin
      tick = 1'b1; step(); tick = 1'b0; step();
      chk("t4_dwell", 64'(cur_sel), 64'd3);
    end
    tick = 1'b1; step(); tick = 1'b0; step();
    chk("t4_wrap", 64'(cur_sel), 64'd0);
    chk("t4_out", 64'(out), 64'h1);
    mode = 2'd2;
    step();
    ch_en = 4'b1111;
    for (int k = 0; k < C; k++) srcw[k] = W'(k + 'h10);
    pack();
    load = 1'b1; sel_in = 2'd2; tick = 1'b1; step(); load = 1'b0; tick = 1'b0;
    step();
    chk("t5_freeze_out", 64'(out), 64'h1);
    chk("t5_freeze_sel", 64'(cur_sel), 64'd0);
    mode = 2'd1; load = 1'b1; sel_in = 2'd1; tick = 1'b1; step(); load = 1'b0; tick = 1'b0;
    chk("t5_coll", 64'(cur_sel), 64'd1);
    for (int t = 0; t < 4; t++) begin
      tick = 1'b1; step(); tick = 1'b0;
    end
    chk("t5_cnt0", 64'(cur_sel), 64'd1);
    tick = 1'b1; step(); tick = 1'b0;
    chk("t5_cnt5", 64'(cur_sel), 64'd2);
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("t6_out", 64'(out), 64'd0);
    chk("t6_sel", 64'(cur_sel), 64'd0);
    chk("t6_sw", 64'(switched), 64'd0);
    mreset();
    #2 rst_n = 1'b1;
    step();
    chk("t6_nosw", 64'(switched), 64'd0);
    step();
    step();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) ch_en = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        srcw[$urandom_range(0, C-1)] = {8'($urandom), 32'($urandom)};
        pack();
      end
      load = $urandom_range(0, 5) == 0;
      sel_in = 2'($urandom);
      tick = $urandom_range(0, 2) == 0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
